// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with parameterised width/depth, occupancy count,
//   almost-full / almost-empty thresholds, overflow / underflow pulses and
//   an optional first-word-fall-through read mode.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wr_en        write request, data_in captured when accepted
//   data_in      write data
//   rd_en        read request (FWFT: pop of the presented word)
//   data_out     read data (registered, or head word in FWFT mode)
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy 0..DEPTH
//   overflow     one-cycle pulse, write rejected
//   underflow    one-cycle pulse, read rejected
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wa;
    logic             ra;

    // All status flags are pure decodes of the registered count.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read frees a slot in the same edge, so a full FIFO can still take a
    // write alongside it. No bypass: a write never satisfies a read on empty.
    assign ra = rd_en && !empty;
    assign wa = wr_en && (!full || ra);

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wa) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) wr_ptr <= wr_ptr + AW'(1);
            if (ra) rd_ptr <= rd_ptr + AW'(1);
            case ({wa, ra})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en && !wa;
            underflow <= rd_en && !ra;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is shown combinationally; zero while nothing is stored.
        always_comb begin
            data_out = '0;
            if (!empty) data_out = mem[rd_ptr];
        end
    end else begin : g_std
        // Registered read: word appears the cycle after the accepting edge
        // and holds until the next accepted read.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out <= '0;
            end else if (ra) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // standard-read instance
    logic          s_wr, s_rd;
    logic [W-1:0]  s_din, s_dout;
    logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic [CW-1:0] s_cnt;

    // FWFT instance
    logic          f_wr, f_rd;
    logic [W-1:0]  f_din, f_dout;
    logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] f_cnt;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
        .data_out(s_dout), .empty(s_empty), .full(s_full),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
        .data_out(f_dout), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic [W-1:0]  din;
        logic [CW-1:0] cnt;   // expected count after the edge
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] last_rd;
    int           total  = 0;
    int           passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic void add(input logic wr, input logic rd, input logic [W-1:0] din,
                                input logic [CW-1:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    // One cycle on the standard instance: drive at negedge, check after posedge.
    task automatic run_row(input vec_t v, input int idx);
        logic [W-1:0] exp_d;
        string tag;
        tag = $sformatf("row%0d", idx);
        @(negedge clk);
        s_wr = v.wr; s_rd = v.rd; s_din = v.din;
        @(posedge clk); #1;
        chk({tag, "_count"}, 32'(s_cnt), 32'(v.cnt));
        chk({tag, "_empty"}, 32'(s_empty), 32'(v.cnt == 0));
        chk({tag, "_full"},  32'(s_full),  32'(v.cnt == 8));
        chk({tag, "_af"},    32'(s_af),    32'(v.cnt >= 6));
        chk({tag, "_ae"},    32'(s_ae),    32'(v.cnt <= 2));
        chk({tag, "_ovf"},   32'(s_ovf),   32'(v.ovf));
        chk({tag, "_unf"},   32'(s_unf),   32'(v.unf));
        if (v.rd && !v.unf) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'(1), 32'(0));
            end else begin
                exp_d = sb.pop_front();
                last_rd = exp_d;
                chk({tag, "_data"}, 32'(s_dout), 32'(exp_d));
            end
        end else if (v.rd) begin
            chk({tag, "_hold"}, 32'(s_dout), 32'(last_rd));
        end
        if (v.wr && !v.ovf) sb.push_back(v.din);
    endtask

    task automatic cyc_f(input logic wr, input logic rd, input logic [W-1:0] din);
        @(negedge clk);
        f_wr = wr; f_rd = rd; f_din = din;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        s_wr = 0; s_rd = 0; s_din = '0;
        f_wr = 0; f_rd = 0; f_din = '0;
        last_rd = '0;

        // 1: fill, then overflow on a full FIFO
        for (int i = 1; i <= 8; i++) add(1, 0, 8'(i), 4'(i), 0, 0);
        add(1, 0, 8'hFF, 4'd8, 1, 0);
        add(0, 0, 8'h00, 4'd8, 0, 0);
        // 2: drain, then underflow with data_out held
        for (int i = 1; i <= 8; i++) add(0, 1, 8'h00, 4'(8 - i), 0, 0);
        add(0, 1, 8'h00, 4'd0, 0, 1);
        add(0, 0, 8'h00, 4'd0, 0, 0);
        // 3: wrap 4 x (write 5, read 5), values 10..23
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) add(1, 0, 8'(8'h10 + r * 5 + k), 4'(k + 1), 0, 0);
            for (int k = 0; k < 5; k++) add(0, 1, 8'h00, 4'(4 - k), 0, 0);
        end
        // empty + rd + wr: write taken, read rejected
        add(1, 1, 8'h55, 4'd1, 0, 1);
        add(0, 1, 8'h00, 4'd0, 0, 0);
        // 4: full + simultaneous read/write
        for (int i = 0; i < 8; i++) add(1, 0, 8'(8'h40 + i), 4'(i + 1), 0, 0);
        add(1, 1, 8'hAA, 4'd8, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 8'h00, 4'(7 - i), 0, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(s_cnt), 32'(0));
        chk("rst_empty", 32'(s_empty), 32'(1));
        chk("rst_full", 32'(s_full), 32'(0));
        chk("rst_ae", 32'(s_ae), 32'(1));
        chk("rst_af", 32'(s_af), 32'(0));
        chk("rst_dout", 32'(s_dout), 32'(0));
        chk("rst_ovf", 32'(s_ovf), 32'(0));
        chk("rst_unf", 32'(s_unf), 32'(0));
        chk("rst_f_dout", 32'(f_dout), 32'(0));
        chk("rst_f_empty", 32'(f_empty), 32'(1));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

        // 6: reset mid-stream with count 5 (write during reset is ignored)
        for (int i = 0; i < 5; i++) begin
            v.wr = 1; v.rd = 0; v.din = 8'(8'h70 + i); v.cnt = 4'(i + 1); v.ovf = 0; v.unf = 0;
            run_row(v, 100 + i);
        end
        @(negedge clk);
        rst = 1'b1; s_wr = 1; s_rd = 0; s_din = 8'hEE;
        @(posedge clk); #1;
        chk("mid_rst_count", 32'(s_cnt), 32'(0));
        chk("mid_rst_empty", 32'(s_empty), 32'(1));
        chk("mid_rst_ae", 32'(s_ae), 32'(1));
        chk("mid_rst_af", 32'(s_af), 32'(0));
        chk("mid_rst_dout", 32'(s_dout), 32'(0));
        sb.delete();
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0; s_wr = 0;
        v.wr = 1; v.rd = 0; v.din = 8'hC3; v.cnt = 4'd1; v.ovf = 0; v.unf = 0;
        run_row(v, 200);
        v.wr = 0; v.rd = 1; v.din = 8'h00; v.cnt = 4'd0;
        run_row(v, 201);

        // 5: FWFT instance
        cyc_f(1, 0, 8'h5A);
        chk("fwft_head", 32'(f_dout), 32'(8'h5A));
        chk("fwft_not_empty", 32'(f_empty), 32'(0));
        chk("fwft_count1", 32'(f_cnt), 32'(1));
        cyc_f(0, 0, 8'h00);
        chk("fwft_head_stays", 32'(f_dout), 32'(8'h5A));
        cyc_f(0, 1, 8'h00);
        chk("fwft_pop_empty", 32'(f_empty), 32'(1));
        chk("fwft_pop_dout0", 32'(f_dout), 32'(0));
        chk("fwft_pop_count", 32'(f_cnt), 32'(0));
        cyc_f(1, 1, 8'h33);
        chk("fwft_unf", 32'(f_unf), 32'(1));
        chk("fwft_unf_count", 32'(f_cnt), 32'(1));
        chk("fwft_unf_dout", 32'(f_dout), 32'(8'h33));
        cyc_f(1, 0, 8'h61);
        chk("fwft_two_count", 32'(f_cnt), 32'(2));
        chk("fwft_two_head", 32'(f_dout), 32'(8'h33));
        chk("fwft_unf_clear", 32'(f_unf), 32'(0));
        cyc_f(0, 1, 8'h00);
        chk("fwft_next_head", 32'(f_dout), 32'(8'h61));
        chk("fwft_next_count", 32'(f_cnt), 32'(1));
        cyc_f(0, 1, 8'h00);
        chk("fwft_drain_dout", 32'(f_dout), 32'(0));
        chk("fwft_drain_empty", 32'(f_empty), 32'(1));
        cyc_f(0, 0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO and next-generation buffer for byte and word streams. It adds:
- configurable data width and depth
- an occupancy count
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- a selectable first-word-fall-through (FWFT) read mode

It sits between a producer and a consumer in a single clock domain and replaces the fixed 8x8 FIFO in new designs.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 8: number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- data_in  in  WIDTH  write data.
- rd_en  in  1  read request (FWFT: acknowledge/pop of the presented word).
- data_out  out  WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset and clocking: single clock, clk; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - pointers = 0, count = 0, data_out = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), i.e. 0 for legal values
  - overflow = 0, underflow = 0
  - Memory contents are not cleared.
  - Reset asserted mid-stream discards all stored data; the cycle after reset matches the post-reset state.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- count is a registered up/down counter; it is the sole source of all status flags, which are combinational decodes of count.
- Write accept (wa) = wr_en && (!full || ra).
  - On wa: mem[wr_ptr] <= data_in; wr_ptr++.
  - Simultaneous read and write while full: both are accepted and count is unchanged.
- Read accept (ra) = rd_en && !empty.
  - A write in the same cycle never satisfies a read from an empty FIFO (no bypass).
  - Empty + rd_en + wr_en: the write is accepted, the read is rejected (underflow pulse), and count becomes 1.
- count update: +1 on wa only; -1 on ra only; unchanged if both or neither.
- overflow <= wr_en && !wa for one cycle; no state change on a rejected write.
- underflow <= rd_en && !ra for one cycle; no state change on a rejected read.
- FWFT = 0 (standard read):
  - On ra: data_out <= mem[rd_ptr]; rd_ptr++.
  - Data is valid the cycle after the accepting edge (1-cycle latency).
  - data_out holds its last value otherwise.
- FWFT = 1 (first-word-fall-through):
  - data_out = mem[rd_ptr] whenever !empty; data_out = 0 when empty.
  - The head word is visible the cycle after the write edge that made count 1.
  - rd_en pops it: rd_ptr++ on ra, and the next word, if any, is presented in the following cycle.
- Flags (empty, full, almost_*) change in the cycle after the edge that changes count.
- Order is preserved strictly FIFO across any number of wraps.
- Illegal parameters (non-power-of-two DEPTH, thresholds out of range) are rejected at elaboration.

Test Plan:
1. Reset, then write 8'h01..8'h08 (DEPTH=8, FWFT=0) -> count 8, full=1, almost_full asserted from count 6; 9th write 8'hFF -> overflow pulse 1 cycle, count stays 8, data not stored.
2. Read 8 words from full -> data_out 01..08, each 1 cycle after rd_en; empty=1 after the last read; a further rd_en -> underflow pulse, data_out holds 08.
3. Wrap: write 5, read 5, repeated 4 times with values 10..23 -> outputs match in order, count returns to 0, pointers wrap without loss.
4. Full + simultaneous wr_en (8'hAA) and rd_en -> count stays 8, head word is output, AA is read last after 7 more reads; no overflow pulse.
5. FWFT=1: write 8'h5A into empty -> data_out=5A, empty=0 next cycle with no rd_en; rd_en for 1 cycle -> empty=1, data_out=0; empty + rd_en + wr_en 8'h33 -> underflow pulse, count=1, data_out=33.
6. Assert rst with count=5 mid-stream -> next cycle count=0, empty=1, almost_empty=1, data_out=0; a subsequent write/read of 8'hC3 returns C3.
